// File: rtl/alu_seq_param_if.sv
// Operand/result bundle for alu_seq_param.
// The master drives the request; the slave (the ALU) drives status and result.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       Op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output start, A, B, Op,
    input  busy, done, R, Z, N, C, V
  );

  modport slave (
    input  start, A, B, Op,
    output busy, done, R, Z, N, C, V
  );
endinterface

// File: rtl/alu_seq_param.sv
// Clocked WIDTH-bit ALU (AND/XOR/SUB/MUL) with registered result, Z/N/C/V flags and a start/busy/done handshake.
// Define ALU_FAST_MUL_EN for a single-cycle combinational multiply; otherwise MUL is an iterative shift-add.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_param_if.slave bus
);
  localparam int              CW        = $clog2(WIDTH);
  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_MUL_RUN = 1'b1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);

  // Z and N are always derived from the WIDTH-bit result.
  function automatic logic [1:0] zn_flags(input logic [WIDTH-1:0] res);
    return {(res == {WIDTH{1'b0}}), res[WIDTH-1]};
  endfunction

  logic [0:0]         r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_r;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_op_res;
  logic               w_op_c;
  logic               w_op_v;
  logic               w_mul_op;
  logic [2*WIDTH-1:0] w_mul_term;
  logic [2*WIDTH-1:0] w_mul_add;
`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
`endif

  // Single-cycle operation results and the next shift-add accumulator value.
  always_comb begin
    w_diff = {1'b0, bus.A} - {1'b0, bus.B};
`ifdef ALU_FAST_MUL_EN
    w_prod   = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    w_mul_op = 1'b0;
`else
    w_mul_op = (bus.Op == 2'b11);
`endif
    w_op_res = {WIDTH{1'b0}};
    w_op_c   = 1'b0;
    w_op_v   = 1'b0;
    case (bus.Op)
      2'b00: w_op_res = bus.A & bus.B;
      2'b01: w_op_res = bus.A ^ bus.B;
      2'b10: begin
        w_op_res = w_diff[WIDTH-1:0];
        w_op_c   = ~w_diff[WIDTH];
        w_op_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      2'b11: begin
`ifdef ALU_FAST_MUL_EN
        w_op_res = w_prod[WIDTH-1:0];
        w_op_c   = |w_prod[2*WIDTH-1:WIDTH];
`else
        w_op_res = {WIDTH{1'b0}};
`endif
      end
      default: w_op_res = {WIDTH{1'b0}};
    endcase
    // Partial product for the current multiplier bit; the final bit is folded in on the exit edge.
    w_mul_term = r_mplier[0] ? (r_mcand << r_cnt) : {(2*WIDTH){1'b0}};
    w_mul_add  = r_acc + w_mul_term;
  end

  // Handshake FSM, iterative multiplier and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_r      <= {WIDTH{1'b0}};
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_mul_op) begin
              r_mcand  <= {{WIDTH{1'b0}}, bus.A};
              r_mplier <= bus.B;
              r_acc    <= {(2*WIDTH){1'b0}};
              r_cnt    <= {CW{1'b0}};
              r_busy   <= 1'b1;
              r_state  <= S_MUL_RUN;
            end else begin
              r_r        <= w_op_res;
              {r_z, r_n} <= zn_flags(w_op_res);
              r_c        <= w_op_c;
              r_v        <= w_op_v;
              r_done     <= 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          r_acc    <= w_mul_add;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1'b1);
          if (r_cnt == CNT_LAST) begin
            r_r        <= w_mul_add[WIDTH-1:0];
            {r_z, r_n} <= zn_flags(w_mul_add[WIDTH-1:0]);
            r_c        <= |w_mul_add[2*WIDTH-1:WIDTH];
            r_v        <= 1'b0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.R    = r_r;
  assign bus.Z    = r_z;
  assign bus.N    = r_n;
  assign bus.C    = r_c;
  assign bus.V    = r_v;
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, clocked successor to the 4-bit combinational ALU.
- Same four operations and Z/N/C/V flags, at WIDTH bits.
- Start/busy/done handshake; registered result and flags.
- Multiply is an iterative shift-add unit, so a wide ALU does not need a full array multiplier. Sits between operand/switch registers and display/flag logic on the FPGA controller.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk      input   1      system clock, all state on rising edge
rst_n    input   1      asynchronous active-low reset
start    input   1      request; sampled only when busy=0
A        input   WIDTH  operand A, sampled with start
B        input   WIDTH  operand B, sampled with start
Op       input   2      00 AND, 01 XOR, 10 SUB (A-B), 11 MUL; sampled with start
busy     output  1      operation in progress; start ignored while high
done     output  1      one-cycle pulse: R and flags just updated
R        output  WIDTH  registered result, held until next done
Z        output  1      registered zero flag
N        output  1      registered negative flag
C        output  1      registered carry flag
V        output  1      registered overflow flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n=0). While in reset: state=IDLE, busy=0, done=0, R=0, Z=N=C=V=0, iteration counter and internal registers cleared.
- FSM states: IDLE and MUL_RUN.
- IDLE, start=1, Op!=11:
  - R and flags are written on that same edge.
  - done=1 for the following cycle; state stays IDLE. Latency = 1 cycle.
- IDLE, start=1, Op=11:
  - Latch A as multiplicand and B as multiplier; clear the 2*WIDTH accumulator and counter.
  - busy=1; go to MUL_RUN.
- MUL_RUN: each cycle, if multiplier LSB=1, add multiplicand<<cnt into the accumulator; shift the multiplier right; cnt++.
- MUL_RUN exit: on the edge where cnt reaches WIDTH-1, write R and flags, set done=1, busy=0, go to IDLE.
  - Start sampled at edge k -> result at edge k+WIDTH.
  - done is high during cycle k+WIDTH+1.
- done: high for exactly one cycle per accepted start, never otherwise.
- Back-to-back: start may be asserted in the cycle done is high; it is accepted normally.
- start while busy=1: ignored, no effect on the operation in progress.
- Flags are computed from the WIDTH-bit R for all ops: Z = (R==0), N = R[WIDTH-1].
- AND, XOR: C=0, V=0.
- SUB: R = (A-B) mod 2^WIDTH.
  - C = 1 when A >= B unsigned (no borrow).
  - V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- MUL: unsigned product P (2*WIDTH bits); R = P[WIDTH-1:0].
  - C = |P[2*WIDTH-1:WIDTH].
  - V = 0.
- Counter width is $clog2(WIDTH). No overflow of the internal accumulator is possible.
- Reset mid-MUL_RUN: the operation is aborted, done is not pulsed, and all outputs go to reset values.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MUL is computed combinationally from the sampled operands and handled exactly like the other ops. 1-cycle latency, busy never asserts, MUL_RUN unused. Flags unchanged.
- Undefined: iterative WIDTH-cycle multiply as above.

Test Plan (WIDTH=8, ALU_FAST_MUL_EN undefined unless noted):
- Reset, then AND with A=0xF0, B=0x3C, Op=00 -> R=0x30, Z=0 N=0 C=0 V=0, done pulse 1 cycle after start, busy stays 0.
- SUB 0x05-0x05 -> R=0x00 Z=1 N=0 C=1 V=0; then SUB 0x80-0x01 -> R=0x7F V=1 C=1 N=0; then SUB 0x01-0x02 -> R=0xFF N=1 C=0 V=0.
- MUL 0x0C*0x0B -> busy=1 for 8 cycles; R=0x84 N=1 C=0 Z=0; done exactly 8 edges after start. A second start (XOR) issued mid-run is ignored; R stays 0x84.
- MUL 0x10*0x10 -> R=0x00 Z=1 C=1 V=0; then MUL 0xFF*0xFF -> R=0x01 C=1; the second start is asserted in the done cycle and is accepted.
- rst_n pulled low at cycle 4 of MUL 0x0F*0x0F -> busy=0, R=0, flags=0 immediately (asynchronously); no done pulse after rst_n release.
- ALU_FAST_MUL_EN defined: MUL 0x0C*0x0B -> R=0x84, done 1 cycle after start, busy never high.
